neuron_mac: RTL and testbench

//  Single-neuron multiply-accumulate stage that directly feeds the sigmoid activation wrapper.

---
 rtl/neuron_mac.sv | 136 +++++++++++++
 tb/tb_neuron_mac.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Single-neuron MAC feeding the sigmoid stage: streams N_INPUTS (pixel, weight) beats onto a bias.
// Latency: result valid 2 cycles after the last beat; one beat per cycle, no bubbles.
// Backpressure: in_ready low outside ACCUM; dout/out_valid held until out_ready.
module neuron_mac #(
    parameter int N_INPUTS   = 784,
    parameter int IN_W       = 8,
    parameter int WT_W       = 16,
    parameter int ACC_W      = 22,
    parameter int FRAC_SHIFT = 4,
    parameter int GUARD      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ACC_W-1:0] bias,
    input  logic [IN_W-1:0]  x_in,
    input  logic [WT_W-1:0]  w_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat,
    output logic             busy
);
    localparam int P_W   = IN_W + 1 + WT_W;
    localparam int INT_W = ACC_W + GUARD;
    localparam int CNT_W = $clog2(N_INPUTS + 1);

    localparam logic signed [INT_W-1:0] ACC_MAX = {{(GUARD+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] ACC_MIN = {{(GUARD+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [INT_W-1:0]  acc_q, acc_d;
    logic signed [P_W-1:0]    p_q, p_d;
    logic                     pv_q, pv_d;
    logic                     out_valid_q, out_valid_d;
    logic [ACC_W-1:0]         dout_q, dout_d;
    logic                     sat_q, sat_d;

    logic                     beat;
    logic signed [P_W-1:0]    prod;
    logic signed [INT_W-1:0]  p_ext;
    logic signed [INT_W-1:0]  p_shift;
    logic signed [INT_W-1:0]  acc_sum;

    assign in_ready  = (state_q == ACCUM) && (cnt_q < CNT_W'(N_INPUTS));
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign sat       = sat_q;
    assign beat      = in_valid && in_ready;

    always_comb begin
        prod    = $signed({1'b0, x_in}) * $signed(w_in);
        p_ext   = {{(INT_W-P_W){p_q[P_W-1]}}, p_q};
        // Arithmetic shift floors toward -inf, matching the Q.18 -> Q.14 truncation
        p_shift = p_ext >>> FRAC_SHIFT;
        acc_sum = pv_q ? (acc_q + p_shift) : acc_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        p_d         = beat ? prod : p_q;
        pv_d        = beat;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        sat_d       = sat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = {{GUARD{bias[ACC_W-1]}}, bias};
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_sum;
                if (beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_INPUTS - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Last product lands here; result is registered alongside out_valid
                acc_d       = acc_sum;
                out_valid_d = 1'b1;
                state_d     = DONE;
                if (acc_sum > ACC_MAX) begin
                    dout_d = {1'b0, {(ACC_W-1){1'b1}}};
                    sat_d  = 1'b1;
                end else if (acc_sum < ACC_MIN) begin
                    dout_d = {1'b1, {(ACC_W-1){1'b0}}};
                    sat_d  = 1'b1;
                end else begin
                    dout_d = acc_sum[ACC_W-1:0];
                    sat_d  = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            pv_q        <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            pv_q        <= pv_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            sat_q       <= sat_d;
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with N_INPUTS=4; expected sums computed by hand.
module tb_neuron_mac;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [21:0] bias = '0;
    logic [7:0]  x_in = '0;
    logic [15:0] w_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [21:0] dout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sat;
    logic        busy;

    int errors = 0;
    int checks = 0;

    neuron_mac #(.N_INPUTS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .x_in(x_in), .w_in(w_in), .in_valid(in_valid), .in_ready(in_ready),
        .dout(dout), .out_valid(out_valid), .out_ready(out_ready),
        .sat(sat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [21:0] b);
        start = 1'b1;
        bias  = b;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] x, input logic [15:0] w, input int gap);
        int n;
        repeat (gap) tick();
        x_in = x;
        w_in = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Called one step after the 4th beat's accepting edge
    task automatic expect_result(input string tag, input logic [21:0] d, input logic s);
        chk({tag, "_inrdy_after_last"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_ov_early"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_dout"}, {10'd0, dout}, {10'd0, d});
        chk({tag, "_sat"}, {31'd0, sat}, {31'd0, s});
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #7;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sat", {31'd0, sat}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dout", {10'd0, dout}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: 4 x (128*1024 >> 4 = 8192) = 0x8000
        do_start(22'h000000);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) send(8'd128, 16'd1024, 0);
        expect_result("t1", 22'h008000, 1'b0);
        handshake("t1");

        // 4: gapped input and downstream stall
        do_start(22'h000000);
        for (int i = 0; i < 4; i++) send(8'd128, 16'd1024, i);
        expect_result("t4", 22'h008000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_ov", {31'd0, out_valid}, 32'd1);
            chk("t4_hold_dout", {10'd0, dout}, 32'h008000);
            chk("t4_hold_inrdy", {31'd0, in_ready}, 32'd0);
        end
        handshake("t4");

        // 2: 2^20 + 4*522224 = 3137472 -> positive clip
        do_start(22'h100000);
        for (int i = 0; i < 4; i++) send(8'd255, 16'd32767, 0);
        expect_result("t2", 22'h1FFFFF, 1'b1);
        handshake("t2");

        // 3: -2^20 - 4*522240 -> negative clip
        do_start(22'h300000);
        for (int i = 0; i < 4; i++) send(8'd255, 16'h8000, 0);
        expect_result("t3", 22'h200000, 1'b1);
        handshake("t3");

        // 5: start ignored in ACCUM and DONE, then back-to-back run
        do_start(22'h000000);
        send(8'd128, 16'd1024, 0);
        send(8'd128, 16'd1024, 0);
        start = 1'b1;
        bias  = 22'h1FFFFF;
        tick();
        start = 1'b0;
        chk("t5_accum_busy", {31'd0, busy}, 32'd1);
        chk("t5_accum_inrdy", {31'd0, in_ready}, 32'd1);
        send(8'd128, 16'd1024, 0);
        send(8'd128, 16'd1024, 0);
        expect_result("t5a", 22'h008000, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_done_ov", {31'd0, out_valid}, 32'd1);
        chk("t5_done_dout", {10'd0, dout}, 32'h008000);
        // start held across the handshake edge must only take effect one cycle later
        out_ready = 1'b1;
        start = 1'b1;
        bias  = 22'h100000;
        tick();
        out_ready = 1'b0;
        chk("t5_hs_idle", {31'd0, busy}, 32'd0);
        chk("t5_hs_ov", {31'd0, out_valid}, 32'd0);
        tick();
        start = 1'b0;
        chk("t5_b2b_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) send(8'd255, 16'd32767, 0);
        expect_result("t5b", 22'h1FFFFF, 1'b1);

        // 6: async reset mid-run, then fresh run with floor rounding: 16 + 4*(-1) = 12
        handshake("t5b");
        do_start(22'h100000);
        send(8'd255, 16'd32767, 0);
        send(8'd255, 16'd32767, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_inrdy", {31'd0, in_ready}, 32'd0);
        chk("t6_rst_ov", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_sat", {31'd0, sat}, 32'd0);
        chk("t6_rst_dout", {10'd0, dout}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(22'h000010);
        for (int i = 0; i < 4; i++) send(8'd1, 16'hFFFF, 0);
        expect_result("t6", 22'h00000C, 1'b0);
        handshake("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
